// File: rtl/modmul_4051_digit_seq.sv
// rtl/modmul_4051_digit_seq.sv - digit-serial (a*b) mod MOD controller driving an external 3x3 weighted LUT bank
//
// Computes z = (a*b) mod MOD for 12-bit operands. Each operand is split into
// four 3-bit digits. The 16 digit pairs are issued to the external LUT bank one
// per cycle. The LUT returns (a_i*b_j*8^(i+j)) mod MOD, and that value is folded
// into a modular accumulator.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   operand handshake; a, b are sampled only on handshake
//   a, b                 12-bit operands, any value 0..4095
//   out_valid, out_ready result handshake; z is held until accepted
//   z                    result, always < MOD
//   busy                 high whenever the controller is not idle
//   lut_x                {b digit, a digit} presented to the LUT bank
//   lut_sel              LUT weight index i+j (0..6)
//   lut_z                LUT result, LUT_LAT cycles after lut_x/lut_sel change
module modmul_4051_digit_seq #(
  parameter int MOD     = 4051,
  parameter int LUT_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] z,
  output logic        busy,
  output logic [5:0]  lut_x,
  output logic [2:0]  lut_sel,
  input  logic [11:0] lut_z
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [11:0] MOD12      = 12'(MOD);
  localparam logic [12:0] MOD13      = 13'(MOD);
  localparam logic [1:0]  DRAIN_LAST = (LUT_LAT > 0) ? 2'(LUT_LAT - 1) : 2'd0;

  state_t      state;
  logic [11:0] a_r;
  logic [11:0] b_r;
  logic [11:0] acc;
  logic [3:0]  k;
  logic [1:0]  drain_cnt;
  logic [1:0]  issue_pipe;

  logic [11:0] a_red;
  logic [11:0] b_red;
  logic [3:0]  k_nxt;
  logic [12:0] sum;
  logic [11:0] acc_next;
  logic        run_now;
  logic        acc_en;

  function automatic logic [2:0] digit(input logic [11:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    return v[2:0];
      2'd1:    return v[5:3];
      2'd2:    return v[8:6];
      default: return v[11:9];
    endcase
  endfunction

  // One conditional subtract fully reduces any 12-bit input because
  // 4095 - MOD < MOD for any MOD above 2^11.
  assign a_red = (a >= MOD12) ? a - MOD12 : a;
  assign b_red = (b >= MOD12) ? b - MOD12 : b;

  assign k_nxt   = k + 4'd1;
  assign run_now = (state == RUN);

  // A step issued in cycle c is consumed at the end of cycle c+LUT_LAT.
  // The pipe carries "a step is on lut_x" forward so exactly the 16 issued
  // steps get accumulated, even while DRAIN keeps lut_x parked on step 15.
  always_comb begin
    acc_en = 1'b0;
    case (LUT_LAT)
      0:       acc_en = run_now;
      1:       acc_en = issue_pipe[0];
      default: acc_en = issue_pipe[1];
    endcase
    if (!(state == RUN || state == DRAIN)) acc_en = 1'b0;
  end

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, lut_z};
    acc_next = acc;
    if (acc_en) acc_next = (sum >= MOD13) ? 12'(sum - MOD13) : sum[11:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_pipe <= 2'b00;
    end else begin
      issue_pipe <= {issue_pipe[0], run_now};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      z         <= 12'd0;
      lut_x     <= 6'd0;
      lut_sel   <= 3'd0;
      a_r       <= 12'd0;
      b_r       <= 12'd0;
      acc       <= 12'd0;
      k         <= 4'd0;
      drain_cnt <= 2'd0;
    end else begin
      acc <= acc_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r       <= a_red;
            b_r       <= b_red;
            acc       <= 12'd0;
            k         <= 4'd0;
            drain_cnt <= 2'd0;
            // Step 0 goes out on the handshake edge so it is on the bus in cycle 1.
            lut_x     <= {b_red[2:0], a_red[2:0]};
            lut_sel   <= 3'd0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (k == 4'd15) begin
            if (LUT_LAT == 0) begin
              z         <= acc_next;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= DRAIN;
            end
          end else begin
            k       <= k_nxt;
            lut_x   <= {digit(b_r, k_nxt[1:0]), digit(a_r, k_nxt[3:2])};
            lut_sel <= {1'b0, k_nxt[3:2]} + {1'b0, k_nxt[1:0]};
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            // Final accumulate lands on this edge; capture it directly.
            z         <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modmul_4051_digit_seq.sv
// tb/tb_modmul_4051_digit_seq.sv - self-checking bench for modmul_4051_digit_seq at LUT_LAT 0, 1 and 2
module tb_modmul_4051_digit_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [2:0]        in_valid;
  logic [2:0]        in_ready;
  logic [2:0]        out_valid;
  logic [2:0]        out_ready;
  logic [2:0]        busy;
  logic [2:0][11:0]  a;
  logic [2:0][11:0]  b;
  logic [2:0][11:0]  z;
  logic [2:0][11:0]  lut_z;
  logic [2:0][5:0]   lut_x;
  logic [2:0][2:0]   lut_sel;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

  int dir_a[7] = '{1, 64, 0, 4050, 2048, 4095, 4051};
  int dir_b[7] = '{1, 64, 4050, 4050, 2, 2, 777};
  int dir_z[7] = '{1, 45, 0, 1, 45, 88, 0};

  function automatic logic [11:0] lut_f(input logic [5:0] x, input logic [2:0] sel);
    int w;
    case (sel)
      3'd0: w = 1;
      3'd1: w = 8;
      3'd2: w = 64;
      3'd3: w = 512;
      3'd4: w = 45;
      3'd5: w = 360;
      3'd6: w = 2880;
      default: w = 0;
    endcase
    return 12'((int'(x[2:0]) * int'(x[5:3]) * w) % 4051);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [11:0] zc;
    logic [11:0] z1;
    logic [11:0] z2;
    assign zc = lut_f(lut_x[g], lut_sel[g]);
    always @(posedge clk) begin
      z1 <= zc;
      z2 <= z1;
    end
    assign lut_z[g] = (g == 0) ? zc : (g == 1) ? z1 : z2;

    modmul_4051_digit_seq #(.MOD(4051), .LUT_LAT(g)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a[g]),
      .b         (b[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .z         (z[g]),
      .busy      (busy[g]),
      .lut_x     (lut_x[g]),
      .lut_sel   (lut_sel[g]),
      .lut_z     (lut_z[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_reset(input int d, input string tag);
    check($sformatf("%s_d%0d", tag, d),
          32'({in_ready[d], out_valid[d], busy[d], z[d], lut_x[d], lut_sel[d]}),
          32'({1'b1, 1'b0, 1'b0, 12'd0, 6'd0, 3'd0}));
  endtask

  task automatic run_job(input int d, input int av, input int bv, input int ez, input string tag);
    int n;
    out_ready[d] = 1'b1;
    a[d] = 12'(av);
    b[d] = 12'(bv);
    in_valid[d] = 1'b1;
    n = 0;
    while (!in_ready[d] && n < 100) begin tick(); n++; end
    check($sformatf("%s_ready_d%0d", tag, d), 32'(in_ready[d]), 32'd1);
    exp_q.push_back(12'(ez));
    tick();
    in_valid[d] = 1'b0;
    a[d] = 12'($urandom_range(0, 4095));
    b[d] = 12'($urandom_range(0, 4095));
    n = 1;
    while (!out_valid[d] && n < 200) begin tick(); n++; end
    check($sformatf("%s_lat_d%0d", tag, d), 32'(n), 32'(17 + d));
    if (exp_q.size() > 0) check($sformatf("%s_z_d%0d", tag, d), 32'(z[d]), 32'(exp_q.pop_front()));
    tick();
    check($sformatf("%s_idle_d%0d", tag, d), 32'({in_ready[d], out_valid[d]}), 32'(2'b10));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cycle;
    int sent;
    int outs;
    int ra;
    int rb;
    int out_cyc[3];
    logic hs;
    logic [11:0] held;

    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    a         = '0;
    b         = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) check_reset(d, "reset");

    for (int d = 0; d < 3; d++) begin
      // Directed vectors, including unreduced operands.
      for (int t = 0; t < 7; t++) run_job(d, dir_a[t], dir_b[t], dir_z[t], $sformatf("dir%0d", t));

      // Backpressure: result held, new operands refused.
      out_ready[d] = 1'b0;
      a[d] = 12'd1234;
      b[d] = 12'd567;
      in_valid[d] = 1'b1;
      exp_q.push_back(12'((1234 * 567) % 4051));
      tick();
      in_valid[d] = 1'b0;
      n = 1;
      while (!out_valid[d] && n < 200) begin tick(); n++; end
      check($sformatf("bp_lat_d%0d", d), 32'(n), 32'(17 + d));
      held = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hfff;
      for (int c = 0; c < 5; c++) begin
        in_valid[d] = 1'b1;
        a[d] = 12'($urandom_range(0, 4095));
        b[d] = 12'($urandom_range(0, 4095));
        tick();
        check($sformatf("bp_z_c%0d_d%0d", c, d), 32'(z[d]), 32'(held));
        check($sformatf("bp_hold_c%0d_d%0d", c, d), 32'({in_ready[d], out_valid[d]}), 32'(2'b01));
      end
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b1;
      tick();
      check($sformatf("bp_release_d%0d", d), 32'({in_ready[d], out_valid[d], busy[d]}), 32'(3'b100));

      // Back-to-back throughput with random operands.
      for (int i = 0; i < 3; i++) out_cyc[i] = -1;
      ra = $urandom_range(0, 4095);
      rb = $urandom_range(0, 4095);
      a[d] = 12'(ra);
      b[d] = 12'(rb);
      in_valid[d] = 1'b1;
      exp_q.push_back(12'((ra * rb) % 4051));
      sent = 1;
      outs = 0;
      cycle = 0;
      while (outs < 3 && cycle < 300) begin
        if (out_valid[d]) begin
          out_cyc[outs] = cycle;
          if (exp_q.size() > 0) check($sformatf("tp_z%0d_d%0d", outs, d), 32'(z[d]), 32'(exp_q.pop_front()));
          outs++;
        end
        hs = in_valid[d] && in_ready[d];
        tick();
        cycle++;
        if (hs) begin
          if (sent < 3) begin
            ra = $urandom_range(0, 4095);
            rb = $urandom_range(0, 4095);
            a[d] = 12'(ra);
            b[d] = 12'(rb);
            exp_q.push_back(12'((ra * rb) % 4051));
            sent++;
          end else begin
            in_valid[d] = 1'b0;
          end
        end
      end
      check($sformatf("tp_count_d%0d", d), 32'(outs), 32'd3);
      for (int i = 0; i < 3; i++)
        check($sformatf("tp_cycle%0d_d%0d", i, d), 32'(out_cyc[i]), 32'(17 + d + i * (18 + d)));
      in_valid[d] = 1'b0;
      exp_q.delete();
      n = 0;
      while (!in_ready[d] && n < 50) begin tick(); n++; end

      // Reset in the middle of a job, then a clean job.
      out_ready[d] = 1'b1;
      a[d] = 12'd3000;
      b[d] = 12'd3000;
      in_valid[d] = 1'b1;
      tick();
      in_valid[d] = 1'b0;
      for (int c = 0; c < 7; c++) tick();
      check($sformatf("mid_sel_k7_d%0d", d), 32'(lut_sel[d]), 32'd4);
      rst_n = 1'b0;
      #1;
      check_reset(d, "mid_reset");
      tick();
      rst_n = 1'b1;
      tick();
      check_reset(d, "post_reset");
      run_job(d, 100, 100, 1898, "after_reset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
